// File: rtl/getir_birimi.sv
// RV32 instruction fetch stage: fetch PC, single-outstanding memory handshake,
// one-entry skid buffer and the gtr_* output register toward decode.
module getir_birimi #(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000,
    parameter logic [31:0] NOP_BUYRUK   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_istek_hazir_i,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_buyruk_i,
    input  logic        yrt_atlama_gecerli_i,
    input  logic [30:0] yrt_atlama_ps_i,
    input  logic        ddb_durdur_i,
    input  logic        ddb_bosalt_i,
    output logic [31:0] coz_buyruk_o,
    output logic [30:0] coz_ps_o,
    output logic [30:0] coz_ps_artmis_o,
    output logic        coz_gecerli_o
);
    typedef enum logic [1:0] {ISTEK, BEKLE, AT} durum_t;

    localparam logic [30:0] PS_ILK = BASLANGIC_PS[31:1];

    durum_t      durum, durum_sonraki;
    logic [30:0] ps_r;
    logic [30:0] ps_istek;
    logic        skid_dolu;
    logic [31:0] skid_buyruk;
    logic [30:0] skid_ps;
    logic        el_sikisma;
    logic        yanit_al;
    logic        atla;

    assign atla            = yrt_atlama_gecerli_i;
    // No new request while the skid buffer holds an undelivered word.
    assign bellek_istek_o  = (durum == ISTEK) && !skid_dolu && !rst_i;
    assign bellek_adres_o  = {ps_r[30:1], 2'b00};
    assign el_sikisma      = bellek_istek_o && bellek_istek_hazir_i;
    assign yanit_al        = (durum == BEKLE) && bellek_yanit_gecerli_i;
    assign coz_ps_artmis_o = coz_ps_o + 31'd2;

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            ISTEK: begin
                if (el_sikisma)
                    durum_sonraki = atla ? AT : BEKLE;
            end
            BEKLE: begin
                if (bellek_yanit_gecerli_i)
                    durum_sonraki = ISTEK;
                else if (atla)
                    durum_sonraki = AT;
            end
            AT: begin
                // The in-flight word is dropped; a redirect here keeps discarding until it lands.
                if (bellek_yanit_gecerli_i)
                    durum_sonraki = ISTEK;
            end
            default: durum_sonraki = ISTEK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum    <= ISTEK;
            ps_r     <= PS_ILK;
            ps_istek <= PS_ILK;
        end else begin
            durum <= durum_sonraki;
            if (atla)
                ps_r <= yrt_atlama_ps_i & ~31'd1;
            else if (el_sikisma)
                ps_r <= ps_r + 31'd2;
            if (el_sikisma)
                ps_istek <= ps_r;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_dolu     <= 1'b0;
            skid_buyruk   <= NOP_BUYRUK;
            skid_ps       <= PS_ILK;
            coz_buyruk_o  <= NOP_BUYRUK;
            coz_ps_o      <= PS_ILK;
            coz_gecerli_o <= 1'b0;
        end else if (atla) begin
            skid_dolu     <= 1'b0;
            coz_buyruk_o  <= NOP_BUYRUK;
            coz_gecerli_o <= 1'b0;
        end else if (ddb_durdur_i || ddb_bosalt_i) begin
            // Stall and flush both park an arriving word; only flush bubbles the output.
            if (yanit_al) begin
                skid_dolu   <= 1'b1;
                skid_buyruk <= bellek_buyruk_i;
                skid_ps     <= ps_istek;
            end
            if (!ddb_durdur_i) begin
                coz_buyruk_o  <= NOP_BUYRUK;
                coz_gecerli_o <= 1'b0;
            end
        end else if (skid_dolu) begin
            skid_dolu     <= 1'b0;
            coz_buyruk_o  <= skid_buyruk;
            coz_ps_o      <= skid_ps;
            coz_gecerli_o <= 1'b1;
        end else if (yanit_al) begin
            coz_buyruk_o  <= bellek_buyruk_i;
            coz_ps_o      <= ps_istek;
            coz_gecerli_o <= 1'b1;
        end else begin
            coz_buyruk_o  <= NOP_BUYRUK;
            coz_gecerli_o <= 1'b0;
        end
    end
endmodule

// File: doc/getir_birimi.md
Name: getir_birimi

Overview:
- Instruction fetch stage of the RV32 pipeline. Produces the `gtr_*` stream consumed by the decode/register-read stage: instruction word, PC and incremented PC.
- Keeps the fetch PC and runs a single-outstanding request/response handshake to instruction memory.
- Holds a one-entry skid buffer so a response that arrives during a stall is not lost.
- Obeys stall/flush from the hazard unit (ddb) and branch/jump redirects from the execute stage (yrt).

Parameters:
- BASLANGIC_PS, 32'h4000_0000, reset fetch byte address (bits [1:0] must be 0).
- NOP_BUYRUK, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven to decode when not valid.

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- bellek_istek_o  out  1  fetch request valid.
- bellek_adres_o  out  32  fetch byte address, bits [1:0] always 0.
- bellek_istek_hazir_i  in  1  memory accepts request (handshake = istek & hazir).
- bellek_yanit_gecerli_i  in  1  response valid, one-cycle pulse, at most one per accepted request.
- bellek_buyruk_i  in  32  response instruction word.
- yrt_atlama_gecerli_i  in  1  redirect strobe.
- yrt_atlama_ps_i  in  31  redirect target PC[31:1]; bit [1] of the target is ignored (cleared).
- ddb_durdur_i  in  1  stall: hold decode outputs.
- ddb_bosalt_i  in  1  flush: bubble decode outputs.
- coz_buyruk_o  out  32  instruction to decode.
- coz_ps_o  out  31  PC[31:1] of coz_buyruk_o.
- coz_ps_artmis_o  out  31  coz_ps_o + 2 (PC+4 in [31:1] units).
- coz_gecerli_o  out  1  coz_buyruk_o is a real instruction.

Behaviour:
- Reset (rst_i=1 at an edge):
  - State ISTEK; ps_r = BASLANGIC_PS[31:1]; skid buffer empty.
  - bellek_istek_o=0 during the reset cycle.
  - coz_buyruk_o=NOP_BUYRUK, coz_ps_o=BASLANGIC_PS[31:1], coz_ps_artmis_o=coz_ps_o+2, coz_gecerli_o=0.
- bellek_adres_o = {ps_r[31:2],2'b00} in all states. The address wraps modulo 2^32.
- States:
  - ISTEK:
    - bellek_istek_o = 1 when the skid buffer is empty, else 0.
    - On handshake: latch ps_istek = ps_r, ps_r += 2, go to BEKLE.
    - A response arriving in ISTEK is ignored (covers a stale response after a reset).
  - BEKLE:
    - bellek_istek_o = 0.
    - On bellek_yanit_gecerli_i: route the word (see output register), go to ISTEK.
  - AT (discard):
    - bellek_istek_o = 0.
    - On bellek_yanit_gecerli_i: drop the word, go to ISTEK.
- Output register (coz_*), priority order at each edge:
  1. Redirect: load NOP, gecerli=0.
  2. ddb_durdur_i=1: hold. A response arriving in BEKLE is written to the skid buffer.
  3. ddb_bosalt_i=1: load NOP, gecerli=0. A response arriving in BEKLE goes to the skid buffer. The existing buffer content is kept.
  4. Skid buffer full: load from the buffer, mark it empty. A simultaneous response cannot occur, because no request is issued while the buffer is full.
  5. Response in BEKLE: load {bellek_buyruk_i, ps_istek, ps_istek+2}, gecerli=1.
  6. Otherwise: load NOP, gecerli=0 (ps fields keep their last values).
- Redirect (yrt_atlama_gecerli_i=1), which overrides stall and flush:
  - ps_r = {yrt_atlama_ps_i[31:2],1'b0}; skid buffer cleared.
  - In BEKLE with no response this cycle, or in ISTEK with a handshake this cycle: go to AT.
  - In BEKLE with a response this cycle: drop the response, go to ISTEK.
  - In AT: stay in AT.
  - A handshake on the redirect cycle does not advance ps_r.
- Latency and throughput:
  - Handshake to response takes memory latency L ≥ 1; the word appears on coz_* at the edge after the response.
  - Peak throughput is one instruction every 2 cycles (single outstanding request).
- Reset mid-operation: an in-flight response is discarded by the ISTEK rule. Memory must not return it after a new handshake.

Test Plan:
1. Reset release, memory with hazir=1 and L=1; 0x4000_0000=ADDI, 0x4000_0004=ADD.
   - First cycle after reset: istek=1, adres 0x4000_0000.
   - Two cycles later: coz_buyruk_o=ADDI, coz_ps_o=0x2000_0000, artmis=0x2000_0002, gecerli=1.
   - Next request: adres 0x4000_0004.
2. ddb_durdur_i high for 3 cycles while the ADD response arrives.
   - During the stall: coz_* holds ADDI, buffer full, istek=0.
   - Release: ADD appears next edge with ps 0x2000_0002, then a request to 0x4000_0008.
3. Redirect to ps 0x2000_0080 while in BEKLE, response arriving 2 cycles later.
   - That response is dropped and coz stays NOP, gecerli=0.
   - Next request: adres 0x4000_0100.
4. Redirect on the same cycle as a response.
   - Response dropped; the next cycle requests the target immediately (no AT cycle).
5. ddb_bosalt_i pulse alone.
   - coz_* becomes NOP/gecerli=0 for one cycle; ps_r is not disturbed and the sequential fetch continues.
6. rst_i asserted while in BEKLE; the stale response arrives the cycle after reset.
   - Response ignored; fetch restarts at 0x4000_0000; outputs at their reset values.
